// File: rtl/freq_meter_pkg.sv
// Shared types and defaults for the frequency meter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package freq_meter_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam int DEF_CLK_HZ      = 100_000_000;
  localparam int DEF_GATE_CYCLES = DEF_CLK_HZ;
  localparam int DEF_CNT_W       = 27;

  // Width of a counter that must hold 0..cycles-1, never narrower than 1 bit.
  function automatic int gate_w(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizes sig_in into clk_100MHZ and emits a one-cycle pulse per rising edge.
// Latency: 3 clk from sig_in rise to edge_pulse; 2 more with FREQ_METER_GLITCH_FILTER_EN.
// Backpressure: none; free-running, one pulse per detected edge.
module sync_edge_det (
  input  logic clk_100MHZ,
  input  logic rst_n,
  input  logic sig_in,
  output logic edge_pulse
);

  logic       sync_0;
  logic       sync_1;
  logic       det_in;
  logic       det_d;
  logic [2:0] arm_cnt;

`ifdef FREQ_METER_GLITCH_FILTER_EN
  // Detector inputs only hold real samples once sync, history, filter and delay flops have refilled.
  localparam logic [2:0] ARM_CYCLES = 3'd6;

  logic hist_0;
  logic hist_1;
  logic filt;

  // 3-sample majority vote; a lone one-cycle pulse can never win the vote.
  always_ff @(posedge clk_100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      hist_0 <= 1'b0;
      hist_1 <= 1'b0;
      filt   <= 1'b0;
    end else begin
      hist_0 <= sync_1;
      hist_1 <= hist_0;
      filt   <= (sync_1 & hist_0) | (sync_1 & hist_1) | (hist_0 & hist_1);
    end
  end

  assign det_in = filt;
`else
  // Detector inputs only hold real samples once both sync flops and the delay flop have refilled.
  localparam logic [2:0] ARM_CYCLES = 3'd3;

  assign det_in = sync_1;
`endif

  // Two-flop synchronizer for the asynchronous input.
  always_ff @(posedge clk_100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      sync_0 <= 1'b0;
      sync_1 <= 1'b0;
    end else begin
      sync_0 <= sig_in;
      sync_1 <= sync_0;
    end
  end

  // Previous detector sample for rising-edge comparison.
  always_ff @(posedge clk_100MHZ or negedge rst_n) begin
    if (!rst_n) det_d <= 1'b0;
    else        det_d <= det_in;
  end

  // Post-reset arming so reset values in the pipeline cannot fake an edge.
  always_ff @(posedge clk_100MHZ or negedge rst_n) begin
    if (!rst_n)                     arm_cnt <= 3'd0;
    else if (arm_cnt != ARM_CYCLES) arm_cnt <= arm_cnt + 3'd1;
  end

  assign edge_pulse = det_in & ~det_d & (arm_cnt == ARM_CYCLES);

endmodule

// File: rtl/freq_meter.sv
// Counts sig_in rising edges over back-to-back gate windows of GATE_CYCLES clocks.
// Latency: result and valid appear the cycle after each window's terminal cycle.
// Backpressure: none; valid is a one-cycle pulse, freq_hz/overflow hold until next window.
// Optional: FREQ_METER_GLITCH_FILTER_EN adds a majority filter in sync_edge_det.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int CLK_HZ      = DEF_CLK_HZ,
  parameter int GATE_CYCLES = CLK_HZ,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk_100MHZ,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_hz,
  output logic             valid,
  output logic             overflow
);

  localparam int                GATE_W    = gate_w(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  state_t            state_q;
  state_t            state_nxt;
  logic              measuring;
  logic              terminal;
  logic              edge_pulse;
  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic [CNT_W-1:0]  edge_cnt_nxt;
  logic              win_ovf;
  logic              win_ovf_nxt;

  sync_edge_det u_sync_edge_det (
    .clk_100MHZ (clk_100MHZ),
    .rst_n      (rst_n),
    .sig_in     (sig_in),
    .edge_pulse (edge_pulse)
  );

  // FSM state register.
  always_ff @(posedge clk_100MHZ or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  // FSM next state: enable starts measuring, dropping it abandons the window.
  always_comb begin
    state_nxt = state_q;
    measuring = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) state_nxt = MEASURE;
      end
      MEASURE: begin
        measuring = 1'b1;
        if (!en) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign terminal = measuring && (gate_cnt == GATE_LAST);

  // Edge count including this cycle's edge; an edge beyond full scale marks the window overflowed.
  always_comb begin
    edge_cnt_nxt = edge_cnt;
    win_ovf_nxt  = win_ovf;
    if (edge_pulse) begin
      if (edge_cnt == CNT_MAX) win_ovf_nxt  = 1'b1;
      else                     edge_cnt_nxt = edge_cnt + 1'b1;
    end
  end

  // Gate counter: held at 0 when idle, wraps at the terminal cycle so windows abut.
  always_ff @(posedge clk_100MHZ or negedge rst_n) begin
    if (!rst_n)                     gate_cnt <= '0;
    else if (!measuring || terminal) gate_cnt <= '0;
    else                            gate_cnt <= gate_cnt + 1'b1;
  end

  // Edge counter and sticky overflow: cleared when idle and at each window boundary.
  always_ff @(posedge clk_100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
      win_ovf  <= 1'b0;
    end else if (!measuring || terminal) begin
      edge_cnt <= '0;
      win_ovf  <= 1'b0;
    end else begin
      edge_cnt <= edge_cnt_nxt;
      win_ovf  <= win_ovf_nxt;
    end
  end

  // Output registers: capture a completed window, otherwise hold.
  always_ff @(posedge clk_100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      freq_hz  <= '0;
      overflow <= 1'b0;
      valid    <= 1'b0;
    end else begin
      valid <= terminal;
      if (terminal) begin
        freq_hz  <= edge_cnt_nxt;
        overflow <= win_ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter with GATE_CYCLES=100 (27-bit and 4-bit result instances).
// Latency: inputs driven on negedge or posedge+1, outputs sampled on negedge.
// Backpressure: n/a.
module tb_freq_meter;

  logic        clk_100MHZ = 1'b0;
  logic        rst_n;
  logic        en;
  logic        sig_in;
  logic [26:0] freq_hz;
  logic        valid;
  logic        overflow;
  logic [3:0]  freq_hz_w4;
  logic        valid_w4;
  logic        overflow_w4;

  int   n_pass;
  int   n_total;
  int   sig_period;
  int   sig_high;
  int   sig_ph;
  logic sig_const;

  freq_meter #(.CLK_HZ(100), .GATE_CYCLES(100), .CNT_W(27)) dut (
    .clk_100MHZ (clk_100MHZ),
    .rst_n      (rst_n),
    .en         (en),
    .sig_in     (sig_in),
    .freq_hz    (freq_hz),
    .valid      (valid),
    .overflow   (overflow)
  );

  freq_meter #(.CLK_HZ(100), .GATE_CYCLES(100), .CNT_W(4)) dut_w4 (
    .clk_100MHZ (clk_100MHZ),
    .rst_n      (rst_n),
    .en         (en),
    .sig_in     (sig_in),
    .freq_hz    (freq_hz_w4),
    .valid      (valid_w4),
    .overflow   (overflow_w4)
  );

  always #5 clk_100MHZ = ~clk_100MHZ;

  // Signal generator: period 0 means constant sig_const, else sig_high cycles high per period.
  initial begin
    sig_ph = 0;
    forever begin
      @(posedge clk_100MHZ);
      #1;
      if (sig_period == 0) begin
        sig_in = sig_const;
        sig_ph = 0;
      end else begin
        sig_in = (sig_ph < sig_high);
        sig_ph = (sig_ph + 1 >= sig_period) ? 0 : sig_ph + 1;
      end
    end
  end

  task automatic set_sig(input int period, input int high, input logic level);
    sig_period = period;
    sig_high   = high;
    sig_const  = level;
  endtask

  // Advance negedge by negedge until valid is seen or the budget runs out.
  task automatic wait_valid(input int max_cyc, output bit got, output int cyc);
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < max_cyc) begin
      @(negedge clk_100MHZ);
      cyc++;
      if (valid === 1'b1) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    bit got;
    int cyc;
    repeat (3) @(negedge clk_100MHZ);
    n_total++; if (freq_hz !== 27'd0) $display("FAIL reset_freq: got %0d want 0", freq_hz); else n_pass++;
    n_total++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid); else n_pass++;
    n_total++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else n_pass++;
    n_total++; if (freq_hz_w4 !== 4'd0) $display("FAIL reset_freq_w4: got %0d want 0", freq_hz_w4); else n_pass++;
    n_total++; if (overflow_w4 !== 1'b0) $display("FAIL reset_overflow_w4: got %b want 0", overflow_w4); else n_pass++;
    rst_n = 1'b1;
    set_sig(10, 5, 1'b0);
    wait_valid(150, got, cyc);
    n_total++; if (got !== 1'b0) $display("FAIL idle_no_valid: valid seen after %0d cycles with en=0, want none", cyc); else n_pass++;
    n_total++; if (freq_hz !== 27'd0) $display("FAIL idle_freq_hold: got %0d want 0", freq_hz); else n_pass++;
  endtask

  task automatic test_basic();
    bit got;
    int cyc;
    en = 1'b1;
    wait_valid(300, got, cyc);
    n_total++; if (got !== 1'b1 || cyc != 101) $display("FAIL basic_first_valid: got=%b at cycle %0d, want valid at cycle 101", got, cyc); else n_pass++;
    wait_valid(300, got, cyc);
    n_total++; if (got !== 1'b1 || cyc != 100) $display("FAIL basic_valid_period: got=%b at cycle %0d, want 100", got, cyc); else n_pass++;
    n_total++; if (freq_hz !== 27'd10) $display("FAIL basic_freq: got %0d want 10", freq_hz); else n_pass++;
    n_total++; if (overflow !== 1'b0) $display("FAIL basic_overflow: got %b want 0", overflow); else n_pass++;
    n_total++; if (freq_hz_w4 !== 4'd10 || overflow_w4 !== 1'b0) $display("FAIL basic_w4: got %0d/%b want 10/0", freq_hz_w4, overflow_w4); else n_pass++;
    @(negedge clk_100MHZ);
    n_total++; if (valid !== 1'b0) $display("FAIL basic_valid_width: got %b want 0 one cycle after pulse", valid); else n_pass++;
    wait_valid(300, got, cyc);
    n_total++; if (got !== 1'b1 || cyc != 99 || freq_hz !== 27'd10) $display("FAIL basic_third_window: got=%b cyc=%0d freq=%0d want 1/99/10", got, cyc, freq_hz); else n_pass++;
  endtask

  task automatic test_overflow();
    bit got;
    int cyc;
    set_sig(4, 2, 1'b0);
    wait_valid(300, got, cyc);
    wait_valid(300, got, cyc);
    n_total++; if (got !== 1'b1 || freq_hz !== 27'd25 || overflow !== 1'b0) $display("FAIL ovf_p4_main: got=%b freq=%0d ovf=%b want 1/25/0", got, freq_hz, overflow); else n_pass++;
    n_total++; if (freq_hz_w4 !== 4'd15) $display("FAIL ovf_p4_w4_freq: got %0d want 15", freq_hz_w4); else n_pass++;
    n_total++; if (overflow_w4 !== 1'b1) $display("FAIL ovf_p4_w4_flag: got %b want 1", overflow_w4); else n_pass++;
    set_sig(20, 10, 1'b0);
    wait_valid(300, got, cyc);
    wait_valid(300, got, cyc);
    n_total++; if (got !== 1'b1 || freq_hz_w4 !== 4'd5 || overflow_w4 !== 1'b0) $display("FAIL ovf_p20_w4: got=%b freq=%0d ovf=%b want 1/5/0", got, freq_hz_w4, overflow_w4); else n_pass++;
    n_total++; if (freq_hz !== 27'd5) $display("FAIL ovf_p20_main: got %0d want 5", freq_hz); else n_pass++;
  endtask

  task automatic test_fast();
    bit got;
    int cyc;
    set_sig(2, 1, 1'b0);
    wait_valid(300, got, cyc);
    wait_valid(300, got, cyc);
    n_total++; if (got !== 1'b1 || freq_hz !== 27'd50) $display("FAIL fast_p2: got=%b freq=%0d want 1/50", got, freq_hz); else n_pass++;
    set_sig(0, 0, 1'b1);
    wait_valid(300, got, cyc);
    wait_valid(300, got, cyc);
    n_total++; if (got !== 1'b1 || cyc != 100) $display("FAIL const_valid: got=%b at cycle %0d want pulse at 100", got, cyc); else n_pass++;
    n_total++; if (freq_hz !== 27'd0) $display("FAIL const_freq: got %0d want 0", freq_hz); else n_pass++;
  endtask

  task automatic test_glitch();
    bit got;
    int cyc;
    logic [26:0] want;
`ifdef FREQ_METER_GLITCH_FILTER_EN
    want = 27'd0;
`else
    want = 27'd10;
`endif
    set_sig(10, 1, 1'b0);
    wait_valid(300, got, cyc);
    wait_valid(300, got, cyc);
    n_total++; if (got !== 1'b1 || freq_hz !== want) $display("FAIL glitch_pulses: got=%b freq=%0d want 1/%0d", got, freq_hz, want); else n_pass++;
  endtask

  task automatic test_en_drop();
    bit got;
    int cyc;
    set_sig(10, 5, 1'b0);
    wait_valid(300, got, cyc);
    wait_valid(300, got, cyc);
    n_total++; if (got !== 1'b1 || freq_hz !== 27'd10) $display("FAIL endrop_pre: got=%b freq=%0d want 1/10", got, freq_hz); else n_pass++;
    repeat (50) @(negedge clk_100MHZ);
    en = 1'b0;
    set_sig(5, 2, 1'b0);
    wait_valid(150, got, cyc);
    n_total++; if (got !== 1'b0) $display("FAIL endrop_no_valid: valid at cycle %0d want none", cyc); else n_pass++;
    n_total++; if (freq_hz !== 27'd10) $display("FAIL endrop_hold: got %0d want 10", freq_hz); else n_pass++;
    en = 1'b1;
    wait_valid(300, got, cyc);
    n_total++; if (got !== 1'b1 || cyc != 101) $display("FAIL endrop_restart: got=%b at cycle %0d want 101", got, cyc); else n_pass++;
    n_total++; if (freq_hz !== 27'd20 || overflow !== 1'b0) $display("FAIL endrop_new_freq: got %0d/%b want 20/0", freq_hz, overflow); else n_pass++;
  endtask

  task automatic test_async_reset();
    bit got;
    int cyc;
    wait_valid(300, got, cyc);
    n_total++; if (got !== 1'b1 || freq_hz_w4 !== 4'd15 || overflow_w4 !== 1'b1) $display("FAIL areset_pre: got=%b w4=%0d/%b want 1/15/1", got, freq_hz_w4, overflow_w4); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++; if (freq_hz !== 27'd0) $display("FAIL areset_freq: got %0d want 0", freq_hz); else n_pass++;
    n_total++; if (valid !== 1'b0) $display("FAIL areset_valid: got %b want 0", valid); else n_pass++;
    n_total++; if (overflow_w4 !== 1'b0 || freq_hz_w4 !== 4'd0) $display("FAIL areset_w4: got %0d/%b want 0/0", freq_hz_w4, overflow_w4); else n_pass++;
    @(negedge clk_100MHZ);
    rst_n = 1'b1;
    wait_valid(300, got, cyc);
    n_total++; if (got !== 1'b1 || cyc != 101) $display("FAIL areset_idle_restart: got=%b at cycle %0d want 101", got, cyc); else n_pass++;
    wait_valid(300, got, cyc);
    n_total++; if (got !== 1'b1 || freq_hz !== 27'd20) $display("FAIL areset_after: got=%b freq=%0d want 1/20", got, freq_hz); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    en      = 1'b0;
    sig_in  = 1'b0;
    set_sig(0, 0, 1'b0);
    test_reset();
    test_basic();
    test_overflow();
    test_fast();
    test_glitch();
    test_en_drop();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Hard stop in case the sequence stalls.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d of %0d checks passed", n_pass, n_total);
    $fatal(1);
  end

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000: reference clock frequency in Hz.
REQ-002 SHALL have parameter GATE_CYCLES, default CLK_HZ: gate window length in clk_100MHZ cycles (1 s at default).
REQ-003 SHALL have parameter CNT_W, default 27: width of the edge counter and result.
REQ-004 SHALL have port clk_100MHZ, input, 1: the single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port en, input, 1: measurement enable (synchronous).
REQ-007 SHALL have port sig_in, input, 1: external signal to measure, asynchronous to clk_100MHZ.
REQ-008 SHALL have port freq_hz, output, CNT_W: rising edges counted in the last completed gate window.
REQ-009 SHALL have port valid, output, 1: one-cycle pulse when freq_hz updates.
REQ-010 SHALL have port overflow, output, 1: last completed window saturated.

Function
REQ-011 SHALL pass sig_in through a 2-flop synchronizer, then a rising-edge detector (edge = sync & ~sync_d).
REQ-012 SHALL use FSM states IDLE and MEASURE.
- IDLE -> MEASURE when en=1.
- MEASURE -> IDLE when en=0.
REQ-013 In IDLE, the gate counter and edge counter SHALL be held at 0, and outputs SHALL hold their last values.
REQ-014 In MEASURE, the gate counter SHALL count 0..GATE_CYCLES-1 and wrap to 0.
REQ-015 Each detected edge in MEASURE SHALL increment the edge counter.
REQ-016 The edge counter SHALL saturate at 2^CNT_W-1 and set a sticky window-overflow flag.
REQ-017 On the terminal gate cycle (count = GATE_CYCLES-1), the following SHALL happen, with all outputs visible the next cycle:
- freq_hz <= edge count, including any edge detected in that same cycle;
- overflow <= window flag;
- valid <= 1;
- edge counter and window flag cleared.
REQ-018 Windows SHALL be back-to-back with no dead cycles; an edge on cycle 0 of a new window SHALL count in the new window.
REQ-019 valid SHALL be 0 in every cycle other than the one following a terminal gate cycle.
REQ-020 If en falls mid-window, the partial window SHALL be discarded and valid SHALL not pulse.
REQ-021 Maximum measurable rate SHALL be CLK_HZ/2; faster inputs are undefined (aliasing).

Reset
REQ-022 While rst_n=0 the block SHALL be forced to the reset state regardless of clock:
- state = IDLE;
- all counters = 0;
- synchronizer flops = 0;
- freq_hz = 0, valid = 0, overflow = 0.
REQ-023 After rst_n deasserts, the first edge counted SHALL be the first sig_in rising edge seen after synchronization; there SHALL be no spurious edge from reset values.

Configuration
REQ-024 With macro FREQ_METER_GLITCH_FILTER_EN defined, a 3-sample majority filter SHALL be inserted between the synchronizer and the edge detector.
- Adds 2 cycles of edge latency.
- Rejects single-cycle pulses.
REQ-025 Without FREQ_METER_GLITCH_FILTER_EN, the filter SHALL be absent and REQ-011 applies unchanged.

Structure
REQ-026 Package freq_meter_pkg SHALL hold:
- the FSM state typedef (IDLE, MEASURE);
- default constants for CLK_HZ, GATE_CYCLES and CNT_W.
REQ-027 Sub-module sync_edge_det SHALL contain:
- the synchronizer;
- the optional glitch filter;
- the rising-edge detector, with output edge_pulse.
REQ-028 freq_meter SHALL contain only the FSM, the counters and the output registers.

Verification (GATE_CYCLES=100 unless stated)
REQ-029 en=1, sig_in period 10 clk -> valid pulses every 100 clk; freq_hz=10 from the 2nd window on; overflow=0.
REQ-030 CNT_W=4, sig_in period 4 clk -> freq_hz=15, overflow=1; then sig_in period 20 clk -> next full window freq_hz=5, overflow=0.
REQ-031 sig_in toggling every clk (period 2) -> freq_hz=50; sig_in constant 1 -> freq_hz=0 and valid still pulses.
REQ-032 en deasserted at gate count 50 -> no valid pulse and freq_hz unchanged; en re-asserted -> first valid after exactly 100 MEASURE cycles.
REQ-033 rst_n pulsed low mid-window (asynchronously, between clock edges) -> freq_hz, valid and overflow go to 0 immediately, and state = IDLE.
REQ-034 With FREQ_METER_GLITCH_FILTER_EN, 1-clk pulses every 10 clk -> freq_hz=0; without the macro -> freq_hz=10.
